noc_writer: RTL and testbench

//  Transmit side of the fabric port: pops flits from the fabric-to-NoC async FIFO and injects them into the router input.

---
 rtl/noc_writer.sv | 159 +++++++++++++++
 tb/tb_noc_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_writer.sv
// noc_writer: transmit side of the fabric port.
// It pops flits from the fabric-to-NoC show-ahead FIFO and injects them into the router input.
// Flow control uses one credit counter per virtual channel.
// Each packet is given one VC, chosen round-robin among the VCs that hold credit, and keeps it until its tail.
// Optional feature: define NOC_WRITER_CREDIT_CHECK_EN for a sticky credit/protocol error flag.
module noc_writer #(
  parameter int WIDTH        = 36,
  parameter int NUM_VC       = 2,
  parameter int DEPTH_PER_VC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  i_data_in,
  input  logic              i_empty,
  output logic              o_read_en,
  output logic [WIDTH-1:0]  o_flit_out,
  input  logic [NUM_VC-1:0] i_credits_in,
  output logic              o_credit_err
);

  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CW  = $clog2(DEPTH_PER_VC + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH_PER_VC);
  localparam logic [CW-1:0] CRED_ONE = CW'(32'd1);

  typedef enum logic [0:0] {
    ST_ALLOC = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  state_t            r_state;
  logic [VCW-1:0]    r_cur_vc;
  logic [CW-1:0]     r_credit [NUM_VC];
  logic [WIDTH-1:0]  r_flit_out;

  logic              w_head;
  logic              w_tail;
  logic              w_alloc_found;
  logic [VCW-1:0]    w_alloc_vc;
  logic              w_cur_has_credit;
  logic              w_state_ok;
  logic              w_send;
  logic [VCW-1:0]    w_send_vc;
  logic [NUM_VC-1:0] w_send_v;
  logic [NUM_VC-1:0] w_at_max;
  logic [WIDTH-1:0]  w_flit;

  assign w_head = i_data_in[WIDTH-2];
  assign w_tail = i_data_in[WIDTH-3];

  // Round-robin scan starting after the last granted VC; first VC with a non-zero registered credit wins.
  always_comb begin
    logic [VCW-1:0] w_v;
    logic           w_hit;
    w_alloc_found = 1'b0;
    w_alloc_vc    = '0;
    w_v           = '0;
    w_hit         = 1'b0;
    for (int i = 1; i <= NUM_VC; i++) begin
      w_v           = VCW'((int'(r_cur_vc) + i) % NUM_VC);
      w_hit         = ~w_alloc_found & (r_credit[w_v] != '0);
      w_alloc_vc    = w_hit ? w_v : w_alloc_vc;
      w_alloc_found = w_alloc_found | w_hit;
    end
  end

  // Pop/emit decision: heads need any credit in ALLOC; stray non-heads are always popped; SEND needs credit on the held VC.
  always_comb begin
    w_cur_has_credit = (r_credit[r_cur_vc] != '0);
    w_state_ok = (r_state == ST_ALLOC) ? (~w_head | w_alloc_found) : w_cur_has_credit;
    o_read_en  = ~rst & ~i_empty & w_state_ok;
    w_send     = o_read_en & ((r_state == ST_SEND) | w_head);
    w_send_vc  = (r_state == ST_ALLOC) ? w_alloc_vc : r_cur_vc;
  end

  // Per-VC send strobes and full-credit flags used by the counters.
  always_comb begin
    w_send_v = '0;
    w_at_max = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_send_v[v] = w_send & (w_send_vc == VCW'(v));
      w_at_max[v] = (r_credit[v] == CRED_MAX);
    end
  end

  // Outgoing flit: force valid and stamp the VC field; every other bit passes through unchanged.
  always_comb begin
    w_flit                   = i_data_in;
    w_flit[WIDTH-1]          = 1'b1;
    w_flit[WIDTH-4 -: VCW]   = w_send_vc;
  end

  // Credit counters: a send decrements, a return increments, both together cancel, and a return at full credit saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_credit[v] <= CRED_MAX;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        case ({w_send_v[v], i_credits_in[v]})
          2'b10:   r_credit[v] <= r_credit[v] - CRED_ONE;
          2'b01:   r_credit[v] <= w_at_max[v] ? CRED_MAX : (r_credit[v] + CRED_ONE);
          default: r_credit[v] <= r_credit[v];
        endcase
      end
    end
  end

  // Packet FSM with registered flit output; a single-flit packet returns straight to ALLOC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ALLOC;
      r_cur_vc   <= VCW'(NUM_VC - 1);
      r_flit_out <= '0;
    end else begin
      r_flit_out <= w_send ? w_flit : '0;
      case (r_state)
        ST_ALLOC: begin
          if (w_send) begin
            r_cur_vc <= w_alloc_vc;
            r_state  <= w_tail ? ST_ALLOC : ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_send) begin
            r_state <= w_tail ? ST_ALLOC : ST_SEND;
          end
        end
        default: r_state <= ST_ALLOC;
      endcase
    end
  end

  assign o_flit_out = r_flit_out;

`ifdef NOC_WRITER_CREDIT_CHECK_EN
  logic w_discard;
  logic w_overflow;
  logic r_credit_err;

  assign w_discard  = o_read_en & (r_state == ST_ALLOC) & ~w_head;
  assign w_overflow = |(i_credits_in & ~w_send_v & w_at_max);

  // Sticky error: set on a credit return beyond depth or a discarded non-head flit; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit_err <= 1'b0;
    end else begin
      r_credit_err <= r_credit_err | w_discard | w_overflow;
    end
  end

  assign o_credit_err = r_credit_err;
`else
  assign o_credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_writer.sv
// Directed scoreboard bench for noc_writer (DEPTH_PER_VC=4, NUM_VC=2).
module tb_noc_writer;

  localparam int WIDTH = 36;
  localparam int NUM_VC = 2;
  localparam int DEPTH = 4;
`ifdef NOC_WRITER_CREDIT_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  i_data_in;
  logic              i_empty;
  logic              o_read_en;
  logic [WIDTH-1:0]  o_flit_out;
  logic [NUM_VC-1:0] i_credits_in;
  logic              o_credit_err;

  logic [WIDTH-1:0] fifo[$];
  logic [WIDTH-1:0] sb[$];
  int n_assert = 0;
  int n_fail = 0;
  int n_out = 0;

  noc_writer #(.WIDTH(WIDTH), .NUM_VC(NUM_VC), .DEPTH_PER_VC(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_data_in(i_data_in), .i_empty(i_empty),
    .o_read_en(o_read_en), .o_flit_out(o_flit_out),
    .i_credits_in(i_credits_in), .o_credit_err(o_credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    i_empty   = (fifo.size() == 0);
    i_data_in = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  // Input word carries valid=0 and an inverted vc field so that both rewrites are observable.
  task automatic push(input logic h, input logic t, input logic [31:0] pl, input logic emit, input logic vc);
    fifo.push_back({1'b0, h, t, ~vc, pl});
    if (emit) sb.push_back({1'b1, h, t, vc, pl});
    drive_fifo();
  endtask

  task automatic check_rd(input string tag, input logic exp);
    #1;
    check(tag, WIDTH'(o_read_en), WIDTH'(exp));
  endtask

  task automatic check_cnt(input string tag, input int exp);
    check(tag, WIDTH'(n_out), WIDTH'(exp));
  endtask

  task automatic check_err(input string tag, input logic exp);
    check(tag, WIDTH'(o_credit_err), WIDTH'(exp));
  endtask

  // One clock: sample read enable before the edge, model the FIFO pop, then check the registered output.
  task automatic tick();
    logic rd;
    #1;
    rd = o_read_en;
    @(posedge clk);
    #1;
    if (rd && fifo.size() != 0) void'(fifo.pop_front());
    drive_fifo();
    if (o_flit_out[WIDTH-1]) begin
      n_out++;
      if (sb.size() == 0) check("unexpected_flit", o_flit_out, '0);
      else check("flit", o_flit_out, sb.pop_front());
    end else begin
      check("idle_zero", o_flit_out, '0);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_credits_in = '0;
    drive_fifo();
    tick();
    tick();
    check_err("rst_err", 1'b0);
    push(1'b1, 1'b1, 32'h0000_00A0, 1'b0, 1'b0);
    check_rd("rd_in_rst", 1'b0);
    fifo.delete();
    drive_fifo();
    rst = 1'b0;

    // 1) single-flit packet after reset on VC0, visible one cycle after the pop
    push(1'b1, 1'b1, 32'h0000_1111, 1'b1, 1'b0);
    check_rd("t1_rd", 1'b1);
    tick();
    check_cnt("t1_out", 1);
    tick();

    // 2) 6-flit packet with 4 credits: 4 go out, then each credit pulse releases one flit a cycle later
    rst = 1'b1; tick(); rst = 1'b0;
    push(1'b1, 1'b0, 32'h0000_2000, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) push(1'b0, 1'b0, 32'h0000_2000 + 32'(i), 1'b1, 1'b0);
    push(1'b0, 1'b1, 32'h0000_2005, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check_rd("t2_stall", 1'b0);
    tick();
    tick();
    check_cnt("t2_out4", 5);
    check_rd("t2_stall_hold", 1'b0);
    i_credits_in = 2'b01; tick(); i_credits_in = 2'b00;
    check_rd("t2_rd_ret1", 1'b1);
    tick();
    check_cnt("t2_out5", 6);
    check_rd("t2_stall2", 1'b0);
    i_credits_in = 2'b01; tick(); i_credits_in = 2'b00;
    check_rd("t2_rd_ret2", 1'b1);
    tick();
    check_cnt("t2_out6", 7);
    tick();

    // 3) back-to-back 2-flit packets alternate VCs with no gap
    rst = 1'b1; tick(); rst = 1'b0;
    push(1'b1, 1'b0, 32'h0000_3A00, 1'b1, 1'b0);
    push(1'b0, 1'b1, 32'h0000_3A01, 1'b1, 1'b0);
    push(1'b1, 1'b0, 32'h0000_3B00, 1'b1, 1'b1);
    push(1'b0, 1'b1, 32'h0000_3B01, 1'b1, 1'b1);
    push(1'b1, 1'b0, 32'h0000_3C00, 1'b1, 1'b0);
    push(1'b0, 1'b1, 32'h0000_3C01, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check_rd("t3_rd", 1'b1);
      tick();
    end
    check_cnt("t3_out", 13);
    tick();

    // 4) credits now VC0=0, VC1=2: drain VC1, then head waits with no credit anywhere
    push(1'b1, 1'b0, 32'h0000_4100, 1'b1, 1'b1);
    push(1'b0, 1'b1, 32'h0000_4101, 1'b1, 1'b1);
    tick();
    tick();
    check_cnt("t4_out_p", 15);
    push(1'b1, 1'b1, 32'h0000_4200, 1'b1, 1'b0);
    check_rd("t4_no_credit", 1'b0);
    // four VC0 returns; Q pops during the second, a simultaneous send and return
    i_credits_in = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    i_credits_in = 2'b00;
    // VC1=0, VC0=3, cur_vc=0: R skips VC1; exactly three VC0 sends fit
    push(1'b1, 1'b1, 32'h0000_4300, 1'b1, 1'b0);
    push(1'b1, 1'b1, 32'h0000_4301, 1'b1, 1'b0);
    push(1'b1, 1'b1, 32'h0000_4302, 1'b1, 1'b0);
    push(1'b1, 1'b1, 32'h0000_4303, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_rd("t4_rd_vc0", 1'b1);
      tick();
    end
    check_rd("t5_credit_exact", 1'b0);
    i_credits_in = 2'b10; tick(); i_credits_in = 2'b00;
    check_rd("t4_rd_vc1", 1'b1);
    tick();
    check_cnt("t4_out", 20);

    // 5) return at full credit saturates; error flag only with the check enabled
    rst = 1'b1; tick(); rst = 1'b0;
    i_credits_in = 2'b01; tick(); i_credits_in = 2'b00;
    check_err("t5_ovf_err", ERR_EN);
    push(1'b1, 1'b0, 32'h0000_5000, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) push(1'b0, 1'b0, 32'h0000_5000 + 32'(i), 1'b1, 1'b0);
    push(1'b0, 1'b0, 32'h0000_5004, 1'b0, 1'b0);
    push(1'b0, 1'b1, 32'h0000_5005, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check_rd("t5_saturated", 1'b0);
    check_cnt("t5_out", 24);

    // 6) reset mid-packet abandons it; leftover non-head flits are discarded
    rst = 1'b1;
    check_rd("t6_rd_in_rst", 1'b0);
    tick();
    check_err("t6_err_clr", 1'b0);
    rst = 1'b0;
    check_rd("t6_discard_rd", 1'b1);
    tick();
    tick();
    check_cnt("t6_no_emit", 24);
    check_err("t6_discard_err", ERR_EN);
    push(1'b1, 1'b1, 32'h0000_6000, 1'b1, 1'b0);
    check_rd("t6_rd_new", 1'b1);
    tick();
    check_cnt("t6_out", 25);
    check("sb_drained", WIDTH'(sb.size()), WIDTH'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
